// File: rtl/slide_board_ctrl.sv
// Sliding-tile board controller: tracks the empty cell, accepts or rejects one
// direction/undo command per button press, and keeps a bounded undo history.
module slide_board_ctrl #(
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int DEPTH = 8,
   parameter int CNTW  = 10,
   localparam int IDXW = $clog2(ROWS*COLS),
   localparam int HW   = $clog2(DEPTH+1)
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [2:0]      go,
   input  logic [IDXW-1:0] init_pos,
   output logic [IDXW-1:0] empty_pos,
   output logic            move_valid,
   output logic [IDXW-1:0] move_from,
   output logic [IDXW-1:0] move_to,
   output logic            blocked,
   output logic [CNTW-1:0] move_count,
   output logic [HW-1:0]   hist_cnt
);

   // state        | meaning
   // READY        | waiting for a press; a nonzero go is evaluated once
   // WAIT_RELEASE | press consumed; waiting for go to return to 000
   localparam logic [0:0] READY        = 1'b0;
   localparam logic [0:0] WAIT_RELEASE = 1'b1;

   localparam int NCELL = ROWS * COLS;
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [0:0]      state;
   logic [1:0]      hist [0:DEPTH-1];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   top_ptr;
   logic [PW-1:0]   nxt_ptr;
   logic [IDXW-1:0] row;
   logic [IDXW-1:0] col;
   logic [IDXW-1:0] next_pos;
   logic [IDXW-1:0] init_ok;
   logic [1:0]      mdir;
   logic            is_dir;
   logic            is_undo;
   logic            legal;
   logic            cmd_ok;
   logic            eval;
   logic            push;

   // Internal direction code: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT; bit 0 flip gives the opposite
   always_comb begin
      row      = empty_pos / IDXW'(COLS);
      col      = empty_pos % IDXW'(COLS);
      top_ptr  = (wr_ptr == '0) ? PW'(DEPTH-1) : wr_ptr - 1'b1;
      nxt_ptr  = (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      is_dir   = (go >= 3'd1) && (go <= 3'd4);
      is_undo  = (go == 3'd5);
      mdir     = is_undo ? (hist[top_ptr] ^ 2'b01) : 2'(go - 3'd1);
      legal    = 1'b0;
      next_pos = empty_pos;
      case (mdir)
         2'd0: begin legal = row < IDXW'(ROWS-1); next_pos = empty_pos + IDXW'(COLS); end
         2'd1: begin legal = row > '0;            next_pos = empty_pos - IDXW'(COLS); end
         2'd2: begin legal = col < IDXW'(COLS-1); next_pos = empty_pos + 1'b1;        end
         default: begin legal = col > '0;         next_pos = empty_pos - 1'b1;        end
      endcase
      cmd_ok  = (is_dir || (is_undo && (hist_cnt != '0))) && legal;
      eval    = (state == READY) && (go != 3'd0);
      push    = eval && cmd_ok && !is_undo;
      init_ok = ({1'b0, init_pos} >= (IDXW+1)'(NCELL)) ? '0 : init_pos;
   end

   always_ff @(posedge clk) begin
      if (resetn && push)
         hist[wr_ptr] <= mdir;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= READY;
         empty_pos  <= init_ok;
         move_from  <= init_ok;
         move_to    <= init_ok;
         move_valid <= 1'b0;
         blocked    <= 1'b0;
         move_count <= '0;
         hist_cnt   <= '0;
         wr_ptr     <= '0;
      end else begin
         move_valid <= 1'b0;
         blocked    <= 1'b0;
         case (state)
            READY: begin
               if (eval) begin
                  state <= WAIT_RELEASE;
                  if (cmd_ok) begin
                     move_valid <= 1'b1;
                     move_to    <= empty_pos;
                     move_from  <= next_pos;
                     empty_pos  <= next_pos;
                     if (is_undo) begin
                        wr_ptr   <= top_ptr;
                        hist_cnt <= hist_cnt - 1'b1;
                        if (move_count != '0)
                           move_count <= move_count - 1'b1;
                     end else begin
                        wr_ptr <= nxt_ptr;
                        if (hist_cnt != HW'(DEPTH))
                           hist_cnt <= hist_cnt + 1'b1;
                        if (move_count != '1)
                           move_count <= move_count + 1'b1;
                     end
                  end else begin
                     blocked <= 1'b1;
                  end
               end
            end
            WAIT_RELEASE: begin
               if (go == 3'd0)
                  state <= READY;
            end
            default: state <= READY;
         endcase
      end
   end

endmodule

// File: tb/tb_slide_board_ctrl.sv
// Scoreboard bench for slide_board_ctrl: a row/col board model predicts each
// press outcome; a negedge monitor checks every move_valid/blocked pulse.
module tb_slide_board_ctrl;
   localparam int ROWS = 4, COLS = 4, DEPTH = 4, CNTW = 10;
   localparam int IDXW = 4, HW = 3;

   logic            clk = 1'b0;
   logic            resetn = 1'b0;
   logic [2:0]      go = 3'd0;
   logic [IDXW-1:0] init_pos = '0;
   logic [IDXW-1:0] empty_pos, move_from, move_to;
   logic            move_valid, blocked;
   logic [CNTW-1:0] move_count;
   logic [HW-1:0]   hist_cnt;

   slide_board_ctrl #(.ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
      .clk(clk), .resetn(resetn), .go(go), .init_pos(init_pos),
      .empty_pos(empty_pos), .move_valid(move_valid), .move_from(move_from),
      .move_to(move_to), .blocked(blocked), .move_count(move_count),
      .hist_cnt(hist_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit mv;
      int from, to, empty, count, hc, due;
   } exp_t;
   exp_t sbq[$];

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void cmp(string nm, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // Board model: codes 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT; history is a plain queue
   int m_empty = 0, m_from = 0, m_to = 0, m_count = 0;
   int m_hist[$];
   bit m_wait = 0;

   function automatic bit m_legal(int d, int e);
      int r = e / COLS;
      int c = e % COLS;
      case (d)
         1: return r < ROWS - 1;
         2: return r > 0;
         3: return c < COLS - 1;
         4: return c > 0;
         default: return 0;
      endcase
   endfunction

   function automatic int m_apply(int d, int e);
      case (d)
         1: return e + COLS;
         2: return e - COLS;
         3: return e + 1;
         default: return e - 1;
      endcase
   endfunction

   function automatic int m_opp(int d);
      case (d)
         1: return 2;
         2: return 1;
         3: return 4;
         default: return 3;
      endcase
   endfunction

   function automatic void model_eval(int g);
      exp_t e;
      int   d = 0;
      bit   ok = 0;
      if (g >= 1 && g <= 4) begin
         d  = g;
         ok = m_legal(d, m_empty);
      end else if (g == 5 && m_hist.size() > 0) begin
         d  = m_opp(m_hist[$]);
         ok = m_legal(d, m_empty);
      end
      if (ok) begin
         m_to    = m_empty;
         m_empty = m_apply(d, m_empty);
         m_from  = m_empty;
         if (g == 5) begin
            void'(m_hist.pop_back());
            if (m_count > 0) m_count--;
         end else begin
            if (m_count < (1 << CNTW) - 1) m_count++;
            m_hist.push_back(g);
            if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
         end
      end
      e.mv = ok; e.from = m_from; e.to = m_to; e.empty = m_empty;
      e.count = m_count; e.hc = m_hist.size(); e.due = cyc + 1;
      sbq.push_back(e);
   endfunction

   // Drive inputs for one edge, update the model, and return just after that edge
   task automatic tick(input logic [2:0] g, input bit rn = 1'b1, input int ip = 0);
      go = g;
      resetn = rn;
      if (!rn) begin
         init_pos = 4'(ip);
         m_empty = (ip >= ROWS * COLS) ? 0 : ip;
         m_from = m_empty; m_to = m_empty; m_count = 0;
         m_hist.delete();
         m_wait = 0;
      end else if (!m_wait) begin
         if (g != 3'd0) begin
            m_wait = 1;
            model_eval(int'(g));
         end
      end else if (g == 3'd0) begin
         m_wait = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [2:0] g, input int hold);
      for (int i = 0; i < hold; i++) tick(g);
      tick(3'd0);
   endtask

   task automatic check_state(string nm);
      cmp({nm, ".empty_pos"}, int'(empty_pos), m_empty);
      cmp({nm, ".move_count"}, int'(move_count), m_count);
      cmp({nm, ".hist_cnt"}, int'(hist_cnt), m_hist.size());
   endtask

   task automatic check_reset(string nm);
      check_state(nm);
      cmp({nm, ".move_from"}, int'(move_from), m_from);
      cmp({nm, ".move_to"}, int'(move_to), m_to);
      cmp({nm, ".move_valid"}, int'(move_valid), 0);
      cmp({nm, ".blocked"}, int'(blocked), 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (resetn) cmp("pulse_exclusive", int'(move_valid && blocked), 0);
      if (move_valid || blocked) begin
         if (sbq.size() == 0) begin
            cmp("spurious_pulse", 1, 0);
         end else begin
            e = sbq.pop_front();
            cmp("pulse_cycle", cyc, e.due);
            cmp("move_valid", int'(move_valid), int'(e.mv));
            cmp("blocked", int'(blocked), int'(!e.mv));
            cmp("move_from", int'(move_from), e.from);
            cmp("move_to", int'(move_to), e.to);
            cmp("empty_pos", int'(empty_pos), e.empty);
            cmp("move_count", int'(move_count), e.count);
            cmp("hist_cnt", int'(hist_cnt), e.hc);
         end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
         cmp("missing_pulse", 0, 1);
         void'(sbq.pop_front());
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int g, r;
      // single UP press from corner 0
      tick(3'd0, 1'b0, 0);
      check_reset("reset0");
      press(3'd1, 1);
      check_state("up_once");
      // blocked directions at corner 0
      tick(3'd0, 1'b0, 0);
      press(3'd4, 1);
      press(3'd2, 1);
      check_state("corner_blocked");
      // held LEFT gives one move; no row wrap from 7
      tick(3'd0, 1'b0, 5);
      check_reset("reset5");
      press(3'd3, 6);
      check_state("left_held");
      tick(3'd0, 1'b0, 7);
      press(3'd3, 1);
      check_state("no_wrap");
      // moves then undo past empty history
      tick(3'd0, 1'b0, 0);
      press(3'd1, 1); check_state("seq_up");
      press(3'd3, 1); check_state("seq_left");
      press(3'd5, 1); check_state("undo1");
      press(3'd5, 1); check_state("undo2");
      press(3'd5, 1); check_state("undo3");
      // history overflow drops the oldest move
      tick(3'd0, 1'b0, 0);
      press(3'd1, 1); press(3'd3, 1); press(3'd1, 1); press(3'd3, 1); press(3'd1, 1);
      check_state("hist_full");
      for (int i = 0; i < 5; i++) press(3'd5, 2);
      check_state("hist_drained");
      // reset while waiting for release with go held
      tick(3'd0, 1'b0, 5);
      tick(3'd1); tick(3'd1); tick(3'd1);
      tick(3'd1, 1'b0, 5);
      check_reset("reset_in_wait");
      tick(3'd1);
      tick(3'd0);
      press(3'd2, 1);
      check_state("after_reset_press");
      // randomized presses, illegal codes and occasional resets
      for (int i = 0; i < 250; i++) begin
         r = $urandom_range(0, 24);
         if (r == 0) begin
            tick(3'd0, 1'b0, $urandom_range(0, 15));
         end else begin
            g = $urandom_range(0, 9);
            if (g > 7) g = 5;
            press(3'(g), $urandom_range(1, 3));
         end
      end
      check_state("random_end");
      tick(3'd0); tick(3'd0);
      cmp("queue_drained", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
